// File: rtl/neurosa_pkg.sv
// Shared types for the annealing neuron array: spike codes, broadcast width and
// the network scheduler's state encoding.
package neurosa_pkg;

  localparam int TEN_DATA_WIDTH  = 2;
  localparam int NEURON_ID_WIDTH = 8;
  localparam int SPIKE_IN_WIDTH  = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

  typedef enum logic [TEN_DATA_WIDTH-1:0] {
    SPK_NONE = 2'd0,
    SPK_POS  = 2'd1,
    SPK_NEG  = 2'd2
  } spike_code_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GATHER  = 3'd1,
    S_SELECT  = 3'd2,
    S_BCAST   = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } sched_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping to 0. The request vector is rotated by the pointer, then priority-encoded.
module rr_priority_picker #(
  parameter int N     = 256,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Doubling the vector lets a plain right shift perform the wrap-around rotation.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_valid = |i_req;
  assign o_idx   = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                            : w_sum[IDX_W-1:0];

endmodule

// File: rtl/spike_network_scheduler.sv
// Network-phase sequencer: gathers all active neurons, picks one firing neuron
// round-robin, broadcasts {code, id}, pulses networkDone, repeats max_iter times.
module spike_network_scheduler
  import neurosa_pkg::*;
#(
  parameter int NUM_NEURON      = 256,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int ITER_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_l,
  input  logic                                 start,
  input  logic [NEURON_ID_WIDTH-1:0]           active_neuron,
  input  logic [ITER_WIDTH-1:0]                max_iter,
  input  logic [NUM_NEURON-1:0]                en_network,
  input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0] spike_vec,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
  output logic                                 networkDone,
  output logic [ITER_WIDTH-1:0]                iter_count,
  output logic                                 sched_busy,
  output logic                                 sched_done
);

  sched_state_e                                r_state;
  sched_state_e                                w_next_state;
  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0]   r_spike_in;
  logic [NEURON_ID_WIDTH-1:0]                  r_rr_ptr;
  logic [ITER_WIDTH-1:0]                       r_iter_count;

  logic [NUM_NEURON-1:0]      w_active_mask;
  logic [NUM_NEURON-1:0]      w_cand;
  logic                       w_pick_valid;
  logic [NEURON_ID_WIDTH-1:0] w_pick_idx;
  logic [TEN_DATA_WIDTH-1:0]  w_pick_code;
  logic [NEURON_ID_WIDTH:0]   w_ptr_inc;
  logic [NEURON_ID_WIDTH-1:0] w_ptr_next;
  logic                       w_all_emitted;
  logic                       w_all_released;
  logic                       w_run_empty;

  always_comb begin
    w_active_mask = '0;
    w_cand        = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      w_active_mask[i] = (i < int'(active_neuron));
      w_cand[i]        = w_active_mask[i] & (|spike_vec[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH]);
    end
  end

  rr_priority_picker #(
    .N     (NUM_NEURON),
    .IDX_W (NEURON_ID_WIDTH)
  ) u_picker (
    .i_req   (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_pick_code    = spike_vec[w_pick_idx*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
  assign w_ptr_inc      = {1'b0, w_pick_idx} + 1'b1;
  assign w_ptr_next     = (w_ptr_inc == {1'b0, active_neuron}) ? '0
                                                               : w_ptr_inc[NEURON_ID_WIDTH-1:0];
  assign w_all_emitted  = &(en_network | ~w_active_mask);
  // Neurons must drop en_network before the next gather, so a stale request is never re-counted.
  assign w_all_released = ~|(en_network & w_active_mask);
  assign w_run_empty    = (max_iter == '0) || (active_neuron == '0);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = w_run_empty ? S_DONE : S_GATHER;
      S_GATHER:       if (w_all_emitted) w_next_state = S_SELECT;
      S_SELECT:       w_next_state = S_BCAST;
      S_BCAST:        w_next_state = S_RELEASE;
      S_RELEASE:      if (w_all_released)
                        w_next_state = (r_iter_count == max_iter) ? S_DONE : S_GATHER;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state      <= S_IDLE;
      r_spike_in   <= '0;
      r_rr_ptr     <= '0;
      r_iter_count <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        S_IDLE, S_DONE: if (start) r_iter_count <= '0;
        S_SELECT: begin
          if (w_pick_valid) begin
            r_spike_in <= {w_pick_code, w_pick_idx};
            r_rr_ptr   <= w_ptr_next;
          end else begin
            r_spike_in <= '0;
          end
        end
        S_BCAST:  r_iter_count <= r_iter_count + 1'b1;
        default:  ;
      endcase
    end
  end

  assign spike_in    = r_spike_in;
  assign iter_count  = r_iter_count;
  assign networkDone = (r_state == S_BCAST);
  assign sched_busy  = (r_state == S_GATHER) || (r_state == S_SELECT) ||
                       (r_state == S_BCAST)  || (r_state == S_RELEASE);
  assign sched_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_spike_network_scheduler.sv
// Directed bench for spike_network_scheduler: reset, single and repeated broadcasts,
// round-robin wrap, idle iterations, partial gather and reset mid-broadcast.
module tb_spike_network_scheduler;

  localparam int NN = 256;
  localparam int IW = 8;
  localparam int TW = 2;
  localparam int XW = 16;

  logic              clk = 1'b0;
  logic              reset_l;
  logic              start;
  logic [IW-1:0]     active_neuron;
  logic [XW-1:0]     max_iter;
  logic [NN-1:0]     en_network;
  logic [NN*TW-1:0]  spike_vec;
  logic [TW+IW-1:0]  spike_in;
  logic              networkDone;
  logic [XW-1:0]     iter_count;
  logic              sched_busy;
  logic              sched_done;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  spike_network_scheduler #(
    .NUM_NEURON(NN), .NEURON_ID_WIDTH(IW), .TEN_DATA_WIDTH(TW), .ITER_WIDTH(XW)
  ) dut (
    .clk           (clk),
    .reset_l       (reset_l),
    .start         (start),
    .active_neuron (active_neuron),
    .max_iter      (max_iter),
    .en_network    (en_network),
    .spike_vec     (spike_vec),
    .spike_in      (spike_in),
    .networkDone   (networkDone),
    .iter_count    (iter_count),
    .sched_busy    (sched_busy),
    .sched_done    (sched_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (networkDone === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_code(input int idx, input logic [TW-1:0] code);
    spike_vec[idx*TW +: TW] = code;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic start_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int budget);
    bit hit = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (networkDone === 1'b1) begin
        hit = 1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      $display("FAIL %s: networkDone not seen within %0d cycles (got 0, need 1)", name, budget);
      fails++;
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0; start = 1'b0;
    active_neuron = 8'd4; max_iter = 16'd5;
    en_network = '1; spike_vec = '0; set_code(1, 2'd1);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    start_run();
    wait_pulse("reset_prerun", 20);
    reset_l = 1'b0;
    @(negedge clk);
    tests++; if (spike_in !== '0) begin
      $display("FAIL reset_spike_in: got %h need 000", spike_in); fails++; end
    tests++; if (networkDone !== 1'b0) begin
      $display("FAIL reset_networkDone: got %b need 0", networkDone); fails++; end
    tests++; if (iter_count !== '0) begin
      $display("FAIL reset_iter_count: got %0d need 0", iter_count); fails++; end
    tests++; if (sched_done !== 1'b0 || sched_busy !== 1'b0) begin
      $display("FAIL reset_flags: got done=%b busy=%b need 0 0", sched_done, sched_busy); fails++; end
    reset_l = 1'b1;
  endtask

  task automatic test_single_broadcast();
    int p0;
    do_reset();
    active_neuron = 8'd4; max_iter = 16'd1; en_network = '1;
    spike_vec = '0; set_code(1, 2'd1); set_code(2, 2'd2);
    p0 = pulse_cnt;
    start_run();
    wait_pulse("single_pulse", 20);
    tests++; if (spike_in !== 10'h101) begin
      $display("FAIL single_spike_in: got %h need 101", spike_in); fails++; end
    en_network = '0;
    repeat (3) @(negedge clk);
    tests++; if (sched_done !== 1'b1 || iter_count !== 16'd1) begin
      $display("FAIL single_done: got done=%b iter=%0d need 1 1", sched_done, iter_count); fails++; end
    tests++; if (pulse_cnt - p0 !== 1) begin
      $display("FAIL single_pulse_count: got %0d need 1", pulse_cnt - p0); fails++; end
  endtask

  task automatic run_iters(input string name, input int n, input logic [TW+IW-1:0] exp_spk [3]);
    for (int k = 0; k < n; k++) begin
      wait_pulse(name, 20);
      tests++; if (spike_in !== exp_spk[k]) begin
        $display("FAIL %s_spike_%0d: got %h need %h", name, k, spike_in, exp_spk[k]); fails++; end
      en_network = '0;
      begin
        bit early = 0;
        repeat (3) begin
          @(negedge clk);
          if (networkDone !== 1'b0) early = 1;
        end
        tests++; if (early) begin
          $display("FAIL %s_gap_%0d: networkDone got 1 while en_network low, need 0", name, k); fails++; end
      end
      if (k < n - 1) en_network = '1;
    end
  endtask

  task automatic test_round_robin();
    int p0;
    logic [TW+IW-1:0] exp_spk [3];
    exp_spk = '{10'h101, 10'h202, 10'h101};
    do_reset();
    active_neuron = 8'd4; max_iter = 16'd3; en_network = '1;
    spike_vec = '0; set_code(1, 2'd1); set_code(2, 2'd2);
    p0 = pulse_cnt;
    start_run();
    run_iters("rr", 3, exp_spk);
    tests++; if (sched_done !== 1'b1 || iter_count !== 16'd3) begin
      $display("FAIL rr_done: got done=%b iter=%0d need 1 3", sched_done, iter_count); fails++; end
    tests++; if (pulse_cnt - p0 !== 3) begin
      $display("FAIL rr_pulse_count: got %0d need 3", pulse_cnt - p0); fails++; end
  endtask

  task automatic test_no_fire();
    int p0;
    logic [TW+IW-1:0] exp_spk [3];
    exp_spk = '{10'h000, 10'h000, 10'h000};
    do_reset();
    active_neuron = 8'd4; max_iter = 16'd2; en_network = '1; spike_vec = '0;
    p0 = pulse_cnt;
    start_run();
    run_iters("nofire", 2, exp_spk);
    tests++; if (pulse_cnt - p0 !== 2 || sched_done !== 1'b1) begin
      $display("FAIL nofire_pulses: got %0d done=%b need 2 1", pulse_cnt - p0, sched_done); fails++; end
    // Pointer must still be 0: with n0 and n2 firing, n0 is chosen only from pointer 0.
    set_code(0, 2'd1); set_code(2, 2'd2);
    max_iter = 16'd1; en_network = '1;
    start_run();
    wait_pulse("nofire_ptr", 20);
    tests++; if (spike_in !== 10'h100) begin
      $display("FAIL nofire_ptr_kept: got %h need 100", spike_in); fails++; end
    en_network = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_partial_gather();
    int p0;
    do_reset();
    active_neuron = 8'd4; max_iter = 16'd1;
    spike_vec = '0; set_code(3, 2'd2); set_code(5, 2'd1);
    en_network = '0; en_network[0] = 1'b1; en_network[1] = 1'b1;
    en_network[2] = 1'b1; en_network[5] = 1'b1;
    p0 = pulse_cnt;
    start_run();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (pulse_cnt - p0 !== 0 || networkDone !== 1'b0) begin
      $display("FAIL partial_no_pulse: got %0d pulses need 0", pulse_cnt - p0); fails++; end
    tests++; if (sched_busy !== 1'b1 || iter_count !== 16'd0) begin
      $display("FAIL partial_start_ignored: got busy=%b iter=%0d need 1 0", sched_busy, iter_count); fails++; end
    en_network[3] = 1'b1;
    @(negedge clk);
    tests++; if (networkDone !== 1'b0) begin
      $display("FAIL partial_latency1: got %b need 0", networkDone); fails++; end
    @(negedge clk);
    tests++; if (networkDone !== 1'b1) begin
      $display("FAIL partial_latency2: got %b need 1", networkDone); fails++; end
    tests++; if (spike_in !== 10'h203) begin
      $display("FAIL partial_spike_in: got %h need 203", spike_in); fails++; end
    en_network = '0;
    repeat (3) @(negedge clk);
    tests++; if (sched_done !== 1'b1) begin
      $display("FAIL partial_done: got %b need 1", sched_done); fails++; end
  endtask

  task automatic test_zero_iter_and_reset();
    int p0;
    int p1;
    do_reset();
    active_neuron = 8'd4; max_iter = 16'd0; en_network = '1;
    spike_vec = '0; set_code(1, 2'd1);
    p0 = pulse_cnt;
    start_run();
    tests++; if (sched_done !== 1'b1 || sched_busy !== 1'b0) begin
      $display("FAIL zero_iter_done: got done=%b busy=%b need 1 0", sched_done, sched_busy); fails++; end
    active_neuron = 8'd0; max_iter = 16'd2;
    start_run();
    tests++; if (sched_done !== 1'b1 || sched_busy !== 1'b0) begin
      $display("FAIL zero_active_done: got done=%b busy=%b need 1 0", sched_done, sched_busy); fails++; end
    repeat (3) @(negedge clk);
    tests++; if (pulse_cnt - p0 !== 0) begin
      $display("FAIL zero_no_pulse: got %0d need 0", pulse_cnt - p0); fails++; end
    active_neuron = 8'd4; max_iter = 16'd3;
    start_run();
    wait_pulse("bcast_reset", 20);
    reset_l = 1'b0;
    @(negedge clk);
    p1 = pulse_cnt;
    tests++; if (networkDone !== 1'b0 || sched_busy !== 1'b0 || iter_count !== '0) begin
      $display("FAIL bcast_reset_state: got nd=%b busy=%b iter=%0d need 0 0 0",
               networkDone, sched_busy, iter_count); fails++; end
    @(negedge clk);
    reset_l = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (pulse_cnt !== p1 || sched_busy !== 1'b0) begin
      $display("FAIL bcast_reset_quiet: got %0d extra pulses busy=%b need 0 0",
               pulse_cnt - p1, sched_busy); fails++; end
  endtask

  initial begin
    reset_l = 1'b0; start = 1'b0;
    active_neuron = '0; max_iter = '0; en_network = '0; spike_vec = '0;
    test_reset();
    test_single_broadcast();
    test_round_robin();
    test_no_fire();
    test_partial_gather();
    test_zero_iter_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
